// File: rtl/pad_frame_sched_pkg.sv
// Shared definitions for the padding-frame scheduler: FSM encoding and
// the frame-length helper used to size the beat counter.
package pad_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Beats in one unpadded square frame.
  function automatic int frame_beats(input int size);
    return size * size;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; it moves to the other requester whenever the owner finishes a frame.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~last;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/pad_frame_sched.sv
// Grants the shared padding datapath to one of two requesters for a whole
// frame, paces beats with an optional idle gap, and waits for the frame to drain.
module pad_frame_sched
  import pad_frame_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int MIN_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_req,
  input  logic                 s1_req,
  input  logic                 s0_vld,
  input  logic                 s1_vld,
  input  logic [CHANNEL*N-1:0] s0_din,
  input  logic [CHANNEL*N-1:0] s1_din,
  output logic                 s0_rdy,
  output logic                 s1_rdy,
  output logic                 pad_vld,
  output logic [CHANNEL*N-1:0] pad_din,
  input  logic                 pad_end,
  output logic [1:0]           grant,
  output logic                 frame_done,
  output logic [1:0]           fsm_state
);

  localparam int BEATS = frame_beats(SIZE);
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int GW    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP);

  state_t              state;
  logic [CW-1:0]       beat_cnt;
  logic [GW-1:0]       gap_cnt;
  logic                sticky;
  logic [1:0]          arb_gnt;
  logic                arb_ptr;
  logic                gap_zero;
  logic                hs;
  logic                drain_exit;
  logic [CHANNEL*N-1:0] sel_din;

  // Handshake: a beat moves when sX_vld and sX_rdy are both high on a rising
  // edge. rdy never depends on vld, so a requester may hold vld freely and an
  // unaccepted beat is simply not taken (nothing is buffered here).
  assign gap_zero   = (gap_cnt == '0);
  assign s0_rdy     = (state == ST_STREAM) && grant[0] && gap_zero;
  assign s1_rdy     = (state == ST_STREAM) && grant[1] && gap_zero;
  assign hs         = (s0_rdy && s0_vld) || (s1_rdy && s1_vld);
  assign sel_din    = grant[1] ? s1_din : s0_din;
  assign drain_exit = (state == ST_DRAIN) && sticky && pad_end;
  assign fsm_state  = state;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({s1_req, s0_req}),
    .update (drain_exit),
    .last   (grant[1]),
    .gnt    (arb_gnt),
    .ptr    (arb_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      pad_vld    <= 1'b0;
      pad_din    <= '0;
      frame_done <= 1'b0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      sticky     <= 1'b0;
    end else begin
      pad_vld    <= hs;
      frame_done <= 1'b0;
      if (hs) begin
        pad_din <= sel_din;
      end

      // The gap counter runs in every state so pacing survives a short drain.
      if (hs) begin
        gap_cnt <= GAP_LOAD;
      end else if (!gap_zero) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pad_end && (s0_req || s1_req)) begin
            grant    <= arb_gnt;
            sticky   <= 1'b0;
            beat_cnt <= '0;
            state    <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (!pad_end) begin
            sticky <= 1'b1;
          end
          if (hs) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // pad_end must have been seen low before a high level means "drained".
          if (drain_exit) begin
            frame_done <= 1'b1;
            grant      <= 2'b00;
            state      <= ST_IDLE;
          end else if (!pad_end) begin
            sticky <= 1'b1;
          end
        end

        default: begin
          grant <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_frame_sched.sv
// Bench for pad_frame_sched: two instances (gap 0 and gap 2) each run the same
// directed scenarios plus a random phase against a frame-level reference model.
module tb_pad_frame_sched;
  import pad_frame_sched_pkg::*;

  localparam int N       = 8;
  localparam int CHANNEL = 3;
  localparam int SIZE    = 4;
  localparam int W       = N * CHANNEL;
  localparam int FB      = SIZE * SIZE;
  localparam int LIMIT   = 40000;

  logic clk;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   inst_done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int GAP = (g == 0) ? 0 : 2;

    logic         rst;
    logic         s0_req, s1_req, s0_vld, s1_vld;
    logic [W-1:0] s0_din, s1_din;
    logic         s0_rdy, s1_rdy, pad_vld, pad_end, frame_done;
    logic [W-1:0] pad_din;
    logic [1:0]   grant;
    logic [1:0]   fsm_state;

    pad_frame_sched #(.N(N), .CHANNEL(CHANNEL), .SIZE(SIZE), .MIN_GAP(GAP)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .s0_req     (s0_req),
      .s1_req     (s1_req),
      .s0_vld     (s0_vld),
      .s1_vld     (s1_vld),
      .s0_din     (s0_din),
      .s1_din     (s1_din),
      .s0_rdy     (s0_rdy),
      .s1_rdy     (s1_rdy),
      .pad_vld    (pad_vld),
      .pad_din    (pad_din),
      .pad_end    (pad_end),
      .grant      (grant),
      .frame_done (frame_done),
      .fsm_state  (fsm_state)
    );

    // Reference model state: who owns the datapath and how far the frame got.
    int           m_owner  = -1;
    int           m_prefer = 0;
    int           m_beats  = 0;
    int           m_gap    = 0;
    bit           m_drain  = 0;
    bit           m_saw_low = 0;
    bit           m_pv     = 0;
    bit           m_done   = 0;
    logic [W-1:0] m_hold   = '0;
    logic [W-1:0] exp_q[$];

    // Monitor-side bookkeeping and padding-datapath emulation.
    int  pe_mode  = 0;
    int  busy     = 0;
    int  cyc      = 0;
    int  pv_cnt   = 0;
    int  pv_first = 0;
    int  pv_last  = 0;
    int  pv_frame = 0;
    int  pv_span  = 0;

    initial begin
      bit           acc;
      logic [W-1:0] d;
      forever begin
        @(posedge clk);
        m_pv   = 0;
        m_done = 0;
        acc    = 0;
        if (rst) begin
          m_owner = -1; m_prefer = 0; m_beats = 0; m_gap = 0;
          m_drain = 0;  m_saw_low = 0; m_hold = '0;
          exp_q.delete();
        end else begin
          if (m_owner < 0) begin
            if (pad_end && (s0_req || s1_req)) begin
              if (s0_req && s1_req) m_owner = m_prefer;
              else m_owner = s0_req ? 0 : 1;
              m_saw_low = 0;
              m_beats   = 0;
            end
          end else if (!m_drain) begin
            if (m_gap == 0 && ((m_owner == 0) ? s0_vld : s1_vld)) begin
              acc = 1;
              d = (m_owner == 0) ? s0_din : s1_din;
              exp_q.push_back(d);
              m_hold = d;
              m_pv   = 1;
              m_beats++;
              if (m_beats == FB) begin
                m_beats = 0;
                m_drain = 1;
              end
            end
            if (!pad_end) m_saw_low = 1;
          end else begin
            if (m_saw_low && pad_end) begin
              m_done   = 1;
              m_prefer = 1 - m_owner;
              m_owner  = -1;
              m_drain  = 0;
            end else if (!pad_end) begin
              m_saw_low = 1;
            end
          end
          if (acc) m_gap = GAP;
          else if (m_gap > 0) m_gap--;
        end
      end
    end

    initial begin
      logic [1:0] exp_grant;
      forever begin
        @(negedge clk);
        cyc++;
        exp_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check("grant", g, grant, exp_grant);
        check("s0_rdy", g, s0_rdy, (m_owner == 0 && !m_drain && m_gap == 0));
        check("s1_rdy", g, s1_rdy, (m_owner == 1 && !m_drain && m_gap == 0));
        check("pad_vld", g, pad_vld, m_pv);
        check("pad_din_hold", g, pad_din, m_hold);
        check("frame_done", g, frame_done, m_done);
        if (pad_vld === 1'b1) begin
          if (exp_q.size() == 0) check("sb_empty", g, 1, 0);
          else check("sb_data", g, pad_din, exp_q.pop_front());
          if (pv_cnt == 0) pv_first = cyc;
          pv_last = cyc;
          pv_cnt++;
        end
        if (rst) pv_cnt = 0;
        if (frame_done === 1'b1) begin
          pv_frame = pv_cnt;
          pv_span  = pv_last - pv_first;
          pv_cnt   = 0;
        end
        if (pad_vld === 1'b1) busy = $urandom_range(3, 6);
        else if (busy > 0) busy--;
        pad_end = (pe_mode == 1) ? 1'b0 : (pe_mode == 2) ? 1'b1 : (busy == 0);
      end
    end

    task automatic tick();
      @(negedge clk);
      #1;
      s0_din = W'($urandom);
      s1_din = W'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (frame_done !== 1'b1 && n < budget) begin tick(); n++; end
      check(name, g, (n < budget), 1);
    endtask

    task automatic wait_grant(input string name, input logic [1:0] want, input int budget);
      int n = 0;
      while (grant == 2'b00 && n < budget) begin tick(); n++; end
      check(name, g, grant, want);
    endtask

    task automatic wait_beats(input int want, input int budget);
      int n = 0;
      while (m_beats != want && n < budget) begin tick(); n++; end
      check("beat_wait", g, (n < budget), 1);
    endtask

    task automatic drop_all();
      s0_req = 0; s1_req = 0; s0_vld = 0; s1_vld = 0;
    endtask

    initial begin
      int fd;
      pad_end = 1'b1;
      rst = 1; s0_din = '0; s1_din = '0;
      drop_all();
      tick(); tick();
      check("rst_grant", g, grant, 0);
      check("rst_pad_vld", g, pad_vld, 0);
      check("rst_pad_din", g, pad_din, 0);
      check("rst_frame_done", g, frame_done, 0);
      check("rst_rdy", g, {s1_rdy, s0_rdy}, 0);
      rst = 0;
      tick();

      // s0 alone, vld continuous: full frame, paced by the gap.
      s0_req = 1; s0_vld = 1;
      wait_grant("a_grant", 2'b01, 20);
      wait_done("a_done", 300);
      check("a_beats", g, pv_frame, FB);
      check("a_span", g, pv_span, (FB - 1) * (GAP + 1));
      drop_all();
      repeat (4) tick();

      // Both requesting from reset: s0, then s1, then s0 again.
      rst = 1; s0_req = 1; s1_req = 1; s0_vld = 1; s1_vld = 1;
      tick(); tick();
      rst = 0;
      wait_grant("b_first", 2'b01, 20);
      wait_done("b_done1", 300);
      tick();
      wait_grant("b_second", 2'b10, 20);
      wait_done("b_done2", 300);
      tick();
      wait_grant("b_third", 2'b01, 20);
      s0_req = 0; s1_req = 0;
      wait_done("b_done3", 300);
      drop_all();
      repeat (4) tick();

      // s0 pauses for 5 cycles after beat 7; grant must hold.
      s0_req = 1; s0_vld = 1;
      wait_beats(7, 200);
      s0_req = 0; s0_vld = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("c_hold_grant", g, grant, 2'b01);
        check("c_no_pad_vld", g, pad_vld, 0);
        check("c_s1_rdy", g, s1_rdy, 0);
      end
      s0_req = 1; s0_vld = 1;
      wait_done("c_done", 300);
      check("c_beats", g, pv_frame, FB);
      drop_all();
      repeat (4) tick();

      // pad_end low blocks the grant; pad_end stuck high blocks frame_done.
      pe_mode = 1;
      tick();
      s0_req = 1; s0_vld = 1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check("d_no_grant", g, grant, 0);
      end
      pe_mode = 2;
      wait_grant("d_grant", 2'b01, 20);
      s0_req = 0;
      for (int i = 0; i < 200 && !m_drain; i++) tick();
      fd = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (frame_done) fd++;
      end
      check("d_stuck_no_done", g, fd, 0);
      check("d_stuck_state", g, fsm_state, ST_DRAIN);
      pe_mode = 1;
      tick(); tick();
      pe_mode = 0;
      wait_done("d_done", 40);
      drop_all();
      repeat (4) tick();

      // Reset at beat 9, then an s1-only frame streams in full.
      s0_req = 1; s0_vld = 1;
      wait_beats(8, 200);
      rst = 1;
      tick();
      check("e_rst_grant", g, grant, 0);
      check("e_rst_pad_vld", g, pad_vld, 0);
      rst = 0;
      drop_all();
      s1_req = 1; s1_vld = 1;
      wait_grant("e_grant", 2'b10, 20);
      wait_done("e_done", 300);
      check("e_beats", g, pv_frame, FB);
      drop_all();
      repeat (4) tick();

      // Random traffic: requests, valids and occasional resets.
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 9) == 0) s0_req = ~s0_req;
        if ($urandom_range(0, 9) == 0) s1_req = ~s1_req;
        s0_vld = ($urandom_range(0, 3) != 0);
        s1_vld = ($urandom_range(0, 3) != 0);
        rst    = ($urandom_range(0, 249) == 0);
        tick();
      end
      rst = 0;
      drop_all();
      repeat (10) tick();
      check("sb_drained", g, exp_q.size(), 0);
      inst_done[g] = 1;
    end
  end

  initial begin
    int n = 0;
    while (!(inst_done[0] && inst_done[1]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("timeout", -1, (n < LIMIT), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
